// File: rtl/mat_unscan_if.sv
// Sample stream bundle for the inverse zigzag buffer: zigzag-order input with
// valid/ready, raster-order output with valid and end-of-block marker.
interface mat_unscan_if #(
  parameter int DATA_WIDTH = 10
);
  // Handshake: an input beat transfers on a rising edge where vld_in & in_rdy;
  // the output side has no ready, a beat is delivered on every edge vld_out is high.
  logic                  vld_in;
  logic [DATA_WIDTH-1:0] din;
  logic                  in_rdy;
  logic                  vld_out;
  logic [DATA_WIDTH-1:0] dout;
  logic                  out_last;

  modport master (
    output vld_in, din,
    input  in_rdy, vld_out, dout, out_last
  );

  modport slave (
    input  vld_in, din,
    output in_rdy, vld_out, dout, out_last
  );
endinterface

// File: rtl/mat_unscan.sv
// Inverse zigzag reorder buffer: collects one 8x8 block in zigzag order into a
// raster-indexed register array, then streams it out row-major.
module mat_unscan #(
  parameter int DATA_WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  mat_unscan_if.slave       bus,
  output logic              dbg_state   // 0 = WR (filling), 1 = RD (draining)
);

  typedef enum logic {WR = 1'b0, RD = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [5:0]            wcnt, rcnt;
  logic [DATA_WIDTH-1:0] mem [64];
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  vld_out_r, out_last_r;
  logic                  in_rdy_c, accept;

  // Raster position of the k-th zigzag sample.
  function automatic logic [5:0] zz(input logic [5:0] k);
    logic [5:0] r;
    case (k)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  6'd63: r = 6'd63;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    in_rdy_c  = (state == WR);
    accept    = bus.vld_in & in_rdy_c;
    case (state)
      WR: if (accept && wcnt == 6'd63) state_nxt = RD;
      RD: if (rcnt == 6'd63)           state_nxt = WR;
      default: state_nxt = WR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WR;
      wcnt       <= '0;
      rcnt       <= '0;
      vld_out_r  <= 1'b0;
      out_last_r <= 1'b0;
      dout_r     <= '0;
    end else begin
      state      <= state_nxt;
      vld_out_r  <= 1'b0;
      out_last_r <= 1'b0;
      if (accept) begin
        wcnt <= wcnt + 6'd1;
        if (wcnt == 6'd63) rcnt <= '0;
      end
      if (state == RD) begin
        dout_r     <= mem[rcnt];
        vld_out_r  <= 1'b1;
        out_last_r <= (rcnt == 6'd63);
        rcnt       <= rcnt + 6'd1;
      end
    end
  end

  // Storage is deliberately unreset: only fully written blocks are ever read.
  always_ff @(posedge clk) begin
    if (accept) mem[zz(wcnt)] <= bus.din;
  end

  assign bus.in_rdy   = in_rdy_c;
  assign bus.vld_out  = vld_out_r;
  assign bus.out_last = out_last_r;
  assign bus.dout     = dout_r;
  assign dbg_state    = (state == RD);

endmodule

// File: tb/tb_mat_unscan.sv
// Bench for mat_unscan: directed zigzag blocks in, expected raster stream
// queued per block and checked by an independent output monitor.
module tb_mat_unscan;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;
  int   cyc = 0;

  mat_unscan_if #(.DATA_WIDTH(DW)) bus ();

  mat_unscan #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int zz_tab [64] = '{0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,
                      27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,
                      44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];   // {last, data}
  int n_checks = 0;
  int n_pass   = 0;
  int out_pos  = 0;
  int out_start_cyc = 0;
  int blk_start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.vld_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_vld_out: got dout %0h with no beat expected (t=%0t)", bus.dout, $time);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        if (out_pos == 0) out_start_cyc = cyc;
        check("dout", bus.dout, e[DW-1:0]);
        check("out_last", bus.out_last, e[DW]);
        out_pos = (out_pos + 1) % 64;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic [DW-1:0] v);
    int n = 0;
    bus.vld_in = 1'b1;
    bus.din    = v;
    while (bus.in_rdy !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) check("put_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  // kind 0: din=ZZ[k]; kind 1: ZZ[k]+64; kind 2: ZZ[k] odd -> 3FF else 000.
  // Expected raster output is written directly from the raster index i.
  task automatic block(input int kind, input bit gapped);
    logic [DW-1:0] v;
    for (int k = 0; k < 64; k++) begin
      case (kind)
        1:       v = DW'(zz_tab[k] + 64);
        2:       v = (zz_tab[k] % 2 == 1) ? 10'h3FF : 10'h000;
        default: v = DW'(zz_tab[k]);
      endcase
      put(v);
      if (k == 0) blk_start_cyc = cyc;
      if (gapped && k != 63) begin
        bus.vld_in = 1'b0;
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 64; i++) begin
      case (kind)
        1:       exp_q.push_back({(i == 63), DW'(i + 64)});
        2:       exp_q.push_back({(i == 63), (i % 2 == 1) ? 10'h3FF : 10'h000});
        default: exp_q.push_back({(i == 63), DW'(i)});
      endcase
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_vld_out", bus.vld_out, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int s1;
    bus.vld_in = 1'b0;
    bus.din    = '0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_vld_out", bus.vld_out, 0);
    check("reset_out_last", bus.out_last, 0);
    check("reset_dout", bus.dout, 0);
    check("reset_in_rdy", bus.in_rdy, 1);
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Raster recovery, contiguous input; first output 64 edges after first accept.
    block(0, 1'b0);
    bus.vld_in = 1'b0;
    wait_drain();
    check("latency_first_out", out_start_cyc - blk_start_cyc, 64);

    // Gapped input.
    block(0, 1'b1);
    bus.vld_in = 1'b0;
    wait_drain();

    // Input held during read: in_rdy low for exactly 64 cycles, nothing captured.
    block(0, 1'b0);
    check("rd_state", dbg_state, 1);
    bus.din = 10'h3FF;
    n = 0;
    while (bus.in_rdy !== 1'b1 && n < 200) begin
      n++; @(posedge clk); #1;
    end
    bus.vld_in = 1'b0;
    check("in_rdy_low_cycles", n, 64);
    wait_drain();
    block(0, 1'b0);   // would be misordered if wcnt had moved during read
    bus.vld_in = 1'b0;
    wait_drain();

    // Back-to-back blocks with vld_in held high.
    block(0, 1'b0);
    s1 = blk_start_cyc;
    block(1, 1'b0);
    bus.vld_in = 1'b0;
    check("b2b_second_accept_start", blk_start_cyc - s1, 128);
    wait_drain();
    check("b2b_second_out_start", out_start_cyc - s1, 192);

    // Reset mid-block.
    for (int k = 0; k < 30; k++) put(DW'(zz_tab[k]));
    bus.vld_in = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_vld_out", bus.vld_out, 0);
    check("midrst_dout", bus.dout, 0);
    check("midrst_in_rdy", bus.in_rdy, 1);
    rst_n = 1'b1;
    out_pos = 0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_output", bus.vld_out, 0);
    block(0, 1'b0);
    bus.vld_in = 1'b0;
    wait_drain();

    // Width: alternating all-ones / all-zeros by raster index.
    block(2, 1'b0);
    bus.vld_in = 1'b0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
